game_ctrl: RTL and testbench
============================

# game_ctrl

Round sequencer for the board game datapath. Detects the start switch, pulses the board generator, latches the generated 12-cell board, and runs a timed play phase: cell hits, misses, score, rounds and a per-difficulty countdown. It decides win or lose. It sits between the top level (switches, debounced button flags, 1 Hz tick) and `boardGenerator`.

## Interface
Parameters:
- `ROUNDS`, default 4: boards to clear for a win (1–15).
- `MAX_MISS`, default 3: misses that cause a loss (1–7).
- `GEN_WAIT`, default 2: cycles from `gen_en` to board sampling (≥1).

Ports:
- `clk` in 1: system clock; all logic on its rising edge.
- `rst_sw` in 1: synchronous, active-low reset.
- `start` in 1: start switch level, already synchronised.
- `mode` in 2: difficulty, sampled on the start edge.
- `tick` in 1: one-cycle 1 Hz enable pulse.
- `board` in 12: generator output; bit i is 1 when cell i is lit.
- `move_vld` in 1: one-cycle pulse; the player selects a cell.
- `move` in 4: cell index, valid with `move_vld`.
- `gen_en` out 1: one-cycle pulse that requests a new board.
- `cur_board` out 12: live board, with cells cleared as they are hit.
- `state` out 3: FSM state encoding.
- `time_left` out 5: seconds remaining.
- `round` out 4: boards cleared so far.
- `score` out 8: hit count, saturating at 255.
- `misses` out 3: miss count.
- `win`, `lose` out 1 each: result flags, held.

## Operation
- Reset (`rst_sw`=0 at a clock edge): state goes to IDLE. `start_d`, `gen_en`, `cur_board`, `time_left`, `round`, `score`, `misses`, `win` and `lose` all go to 0. Reset overrides everything, including mid-game.
- States and encodings: IDLE=0, GEN=1, WAIT=2, PLAY=3, WIN=4, LOSE=5.
- Start edge: `start` & ~`start_d`, with `start_d` registered every cycle.
- IDLE:
  - A start edge loads `time_left` from `mode`: 0→30, 1→20, 2→15, 3→10.
  - It clears `round`, `score` and `misses`, and moves to GEN.
  - Levels without an edge are ignored, so a switch that is already high does not start a game.
- GEN: hold one cycle with `gen_en`=1, then go to WAIT. The wait counter starts at 0.
- WAIT:
  - Count `GEN_WAIT` cycles, then sample `board` into `cur_board`.
  - If the sampled board is all zero, return to GEN (regenerate). Otherwise go to PLAY.
- PLAY, on `move_vld` with `move` < 12:
  - If `cur_board[move]`=1: clear that bit and increment `score` (saturating).
  - If `cur_board[move]`=0: increment `misses`.
  - `move` ≥ 12 is ignored entirely.
- PLAY, on `tick`: if `time_left` > 0, decrement it.
- PLAY exits, in priority order:
  1. The board becomes all zero this cycle. Increment `round`. If the new `round` equals `ROUNDS`, go to WIN. Otherwise go to GEN; `time_left` is not reloaded and keeps counting across rounds.
  2. `misses` reaches `MAX_MISS`: go to LOSE.
  3. `time_left` reaches 0: go to LOSE.
- WIN and LOSE:
  - `win` or `lose` is 1, and all counters are frozen.
  - `start`=0 returns the FSM to IDLE and clears `win`/`lose`. `score` and `round` hold until the next start edge.
- Abort: `start`=0 in GEN, WAIT or PLAY returns to IDLE next cycle. `gen_en` is forced 0, and counters are held for display.
- `tick` and `move_vld` outside PLAY have no effect.

## Timing
- Start edge sampled at edge N: `state`=GEN and `gen_en`=1 after N+1. `state`=WAIT after N+2.
- `board` is sampled at the edge that ends the `GEN_WAIT`-th WAIT cycle. `cur_board` is valid and `state`=PLAY one cycle later. With the default, PLAY begins 4 cycles after the start edge.
- A move takes effect on `cur_board`, `score` and `misses` at the same edge that samples `move_vld`. The resulting state transition takes effect on that same edge; it is decided combinationally from next-state values.
- Same-cycle `move_vld` and `tick` are both applied. A board clear beats a timeout that lands in the same cycle. A miss limit and a timeout in the same cycle give LOSE.
- `gen_en` is always exactly one cycle wide and never asserts back-to-back. A regenerate loop yields GEN/WAIT periods of 1+`GEN_WAIT` cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset/start:
  - Hold `rst_sw`=0 for 3 cycles → every output is 0 and `state`=0.
  - Raise `start` with `mode`=2 → `gen_en` pulses at +1, `time_left`=15, `state`=3 at +4.
  - With `board`=12'h003: move 0 then move 1 → `score`=2, `round`=1, `state`=1 (GEN).
- Win: `ROUNDS`=4, each board 12'h001, move 0 each round → `round`=4, `win`=1, `state`=4. Drop `start` → `state`=0, `win`=0.
- Misses: `board`=12'h800; moves 0, 1, 2 → `misses`=3, `lose`=1, `state`=5, `cur_board` remains 12'h800.
- Timeout and boundaries:
  - `mode`=3: 10 ticks with no moves → `time_left`=0, `lose`=1.
  - With `time_left`=1 and the last lit cell hit in the same cycle as `tick` → the game does not lose; `round` increments.
- Regenerate, invalid moves and abort:
  - `board`=0 for the first two samples, then 12'h010 → three `gen_en` pulses before PLAY.
  - `move`=13 → no change to any output.
  - Drop `start` mid-PLAY → `state`=0 next cycle, `score` is held.

Source files
------------

// File: rtl/game_ctrl.sv
// game_ctrl: round sequencer for the board game datapath.
// Starts a game, requests boards, runs timed play, decides win/lose.
//
// Ports:
//   clk        in  system clock (rising edge)
//   rst_sw     in  synchronous active-low reset
//   start      in  start switch level (synchronised)
//   mode [1:0] in  difficulty, taken on the start edge
//   tick       in  1 Hz one-cycle enable
//   board[11:0]in  generator output, bit i = cell i lit
//   move_vld   in  one-cycle move strobe
//   move [3:0] in  selected cell index
//   gen_en     out one-cycle new-board request
//   cur_board  out live board, hit cells cleared
//   state[2:0] out FSM state
//   time_left  out seconds remaining
//   round      out boards cleared
//   score      out hits, saturating at 255
//   misses     out miss count
//   win, lose  out held result flags
module game_ctrl #(
  parameter int ROUNDS   = 4,
  parameter int MAX_MISS = 3,
  parameter int GEN_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_sw,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic        tick,
  input  logic [11:0] board,
  input  logic        move_vld,
  input  logic [3:0]  move,
  output logic        gen_en,
  output logic [11:0] cur_board,
  output logic [2:0]  state,
  output logic [4:0]  time_left,
  output logic [3:0]  round,
  output logic [7:0]  score,
  output logic [2:0]  misses,
  output logic        win,
  output logic        lose
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GEN  = 3'd1,
    S_WAIT = 3'd2,
    S_PLAY = 3'd3,
    S_WIN  = 3'd4,
    S_LOSE = 3'd5
  } st_t;

  localparam logic [7:0] WAIT_LAST = 8'(GEN_WAIT - 1);

  st_t         st_q, st_n;
  logic        start_d;
  logic [7:0]  wcnt_q, wcnt_n;
  logic [11:0] cb_n;
  logic [4:0]  tl_n, tl_load;
  logic [3:0]  rd_n;
  logic [7:0]  sc_n;
  logic [2:0]  ms_n;
  logic        start_edge;
  logic [11:0] sel;
  logic        mv_ok, lit;

  assign state      = st_q;
  assign start_edge = start & ~start_d;
  // moves >= 12 shift the one-hot out of range and are also masked
  assign sel        = 12'd1 << move;
  assign mv_ok      = move_vld & (move < 4'd12);
  assign lit        = |(sel & cur_board);

  always_comb begin
    tl_load = 5'd30;
    unique case (mode)
      2'd0: tl_load = 5'd30;
      2'd1: tl_load = 5'd20;
      2'd2: tl_load = 5'd15;
      2'd3: tl_load = 5'd10;
      default: tl_load = 5'd30;
    endcase
  end

  always_comb begin
    st_n   = st_q;
    wcnt_n = wcnt_q;
    cb_n   = cur_board;
    tl_n   = time_left;
    rd_n   = round;
    sc_n   = score;
    ms_n   = misses;
    unique case (st_q)
      S_IDLE: begin
        if (start_edge) begin
          tl_n = tl_load;
          rd_n = '0;
          sc_n = '0;
          ms_n = '0;
          st_n = S_GEN;
        end
      end
      S_GEN: begin
        if (!start) begin
          st_n = S_IDLE;
        end else begin
          st_n   = S_WAIT;
          wcnt_n = '0;
        end
      end
      S_WAIT: begin
        if (!start) begin
          st_n = S_IDLE;
        end else if (wcnt_q == WAIT_LAST) begin
          cb_n = board;
          st_n = (board == '0) ? S_GEN : S_PLAY;
        end else begin
          wcnt_n = wcnt_q + 8'd1;
        end
      end
      S_PLAY: begin
        if (!start) begin
          st_n = S_IDLE;
        end else begin
          if (mv_ok && lit) begin
            cb_n = cur_board & ~sel;
            if (score != 8'hFF) sc_n = score + 8'd1;
          end
          if (mv_ok && !lit) ms_n = misses + 3'd1;
          if (tick && time_left != '0)
            tl_n = time_left - 5'd1;
          // exits judged on next-state values
          if (cb_n == '0) begin
            rd_n = round + 4'd1;
            st_n = (rd_n == 4'(ROUNDS)) ? S_WIN : S_GEN;
          end else if (ms_n >= 3'(MAX_MISS)) begin
            st_n = S_LOSE;
          end else if (tl_n == '0) begin
            st_n = S_LOSE;
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (!start) st_n = S_IDLE;
      end
      default: st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_sw) begin
      st_q      <= S_IDLE;
      start_d   <= 1'b0;
      wcnt_q    <= '0;
      gen_en    <= 1'b0;
      cur_board <= '0;
      time_left <= '0;
      round     <= '0;
      score     <= '0;
      misses    <= '0;
      win       <= 1'b0;
      lose      <= 1'b0;
    end else begin
      st_q      <= st_n;
      start_d   <= start;
      wcnt_q    <= wcnt_n;
      gen_en    <= (st_n == S_GEN);
      cur_board <= cb_n;
      time_left <= tl_n;
      round     <= rd_n;
      score     <= sc_n;
      misses    <= ms_n;
      win       <= (st_n == S_WIN);
      lose      <= (st_n == S_LOSE);
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: table vectors, directed corner sequences and
// randomized play against a behavioural game model.
module tb_game_ctrl;

  localparam int ROUNDS   = 4;
  localparam int MAX_MISS = 3;
  localparam int GEN_WAIT = 2;
  localparam int P_IDLE = 0, P_GEN = 1, P_WAIT = 2;
  localparam int P_PLAY = 3, P_WIN = 4, P_LOSE = 5;

  logic        clk = 1'b0;
  logic        rst_sw = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = '0;
  logic        tick = 1'b0;
  logic [11:0] board = '0;
  logic        move_vld = 1'b0;
  logic [3:0]  move = '0;
  logic        gen_en;
  logic [11:0] cur_board;
  logic [2:0]  state;
  logic [4:0]  time_left;
  logic [3:0]  round;
  logic [7:0]  score;
  logic [2:0]  misses;
  logic        win, lose;

  game_ctrl #(
    .ROUNDS(ROUNDS), .MAX_MISS(MAX_MISS), .GEN_WAIT(GEN_WAIT)
  ) dut (
    .clk(clk), .rst_sw(rst_sw), .start(start), .mode(mode),
    .tick(tick), .board(board), .move_vld(move_vld),
    .move(move), .gen_en(gen_en), .cur_board(cur_board),
    .state(state), .time_left(time_left), .round(round),
    .score(score), .misses(misses), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int rst, st, md, tk, bd, mvv, mv;
    logic [37:0] exp;
  } vec_t;
  vec_t tbl[$];

  // behavioural model of one game
  int       m_phase, m_time, m_round, m_score, m_miss, m_wait;
  bit [11:0] m_cb;
  bit       m_sprev;
  int       secs[4] = '{30, 20, 15, 10};

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] pk(int st, int g, int cb, int tl,
      int rd, int sc, int ms, int w, int l);
    return {3'(st), 1'(g), 12'(cb), 5'(tl), 4'(rd), 8'(sc),
            3'(ms), 1'(w), 1'(l)};
  endfunction

  function automatic logic [37:0] dut_v();
    return {state, gen_en, cur_board, time_left, round, score,
            misses, win, lose};
  endfunction

  function automatic void add(int rst, int st, int md, int tk,
      int bd, int mvv, int mv, logic [37:0] e);
    vec_t v;
    v = '{rst, st, md, tk, bd, mvv, mv, e};
    tbl.push_back(v);
  endfunction

  task automatic wait_play();
    for (int i = 0; i < 50 && state != 3'd3; i++) cyc();
    chk("wait_play", 64'(state), 64'(3));
  endtask

  task automatic new_game(int md, int bd);
    move_vld = 1'b0;
    tick = 1'b0;
    start = 1'b0;
    cyc();
    start = 1'b1;
    mode = 2'(md);
    board = 12'(bd);
  endtask

  task automatic model_step();
    bit e;
    if (!rst_sw) begin
      m_phase = P_IDLE; m_cb = '0; m_time = 0; m_round = 0;
      m_score = 0; m_miss = 0; m_sprev = 0; m_wait = 0;
      return;
    end
    e = start && !m_sprev;
    m_sprev = start;
    if (m_phase != P_IDLE && !start) begin
      m_phase = P_IDLE;
      return;
    end
    case (m_phase)
      P_IDLE: if (e) begin
        m_time = secs[mode];
        m_round = 0; m_score = 0; m_miss = 0;
        m_phase = P_GEN;
      end
      P_GEN: begin
        m_phase = P_WAIT;
        m_wait = GEN_WAIT;
      end
      P_WAIT: begin
        m_wait--;
        if (m_wait == 0) begin
          m_cb = board;
          m_phase = (board == 0) ? P_GEN : P_PLAY;
        end
      end
      P_PLAY: begin
        if (move_vld && move < 12) begin
          if (m_cb[move]) begin
            m_cb[move] = 1'b0;
            if (m_score < 255) m_score++;
          end else begin
            m_miss++;
          end
        end
        if (tick && m_time > 0) m_time--;
        if (m_cb == 0) begin
          m_round++;
          m_phase = (m_round == ROUNDS) ? P_WIN : P_GEN;
        end else if (m_miss >= MAX_MISS || m_time == 0) begin
          m_phase = P_LOSE;
        end
      end
      default: ;
    endcase
  endtask

  initial begin
    int gens;
    bit prev, b2b;

    // rst st md tk board mvv mv | st g cb tl rd sc ms w l
    add(0,0,0,0,'h000,0,0, pk(0,0,'h000, 0,0,0,0,0,0));
    add(0,0,0,0,'h000,0,0, pk(0,0,'h000, 0,0,0,0,0,0));
    add(0,0,0,0,'h000,0,0, pk(0,0,'h000, 0,0,0,0,0,0));
    add(1,1,2,0,'h003,0,0, pk(1,1,'h000,15,0,0,0,0,0));
    add(1,1,2,0,'h003,0,0, pk(2,0,'h000,15,0,0,0,0,0));
    add(1,1,2,0,'h003,0,0, pk(2,0,'h000,15,0,0,0,0,0));
    add(1,1,2,0,'h003,0,0, pk(3,0,'h003,15,0,0,0,0,0));
    add(1,1,2,0,'h003,1,0, pk(3,0,'h002,15,0,1,0,0,0));
    add(1,1,2,0,'h003,1,13,pk(3,0,'h002,15,0,1,0,0,0));
    add(1,1,2,0,'h003,1,1, pk(1,1,'h000,15,1,2,0,0,0));
    add(1,1,2,0,'h800,0,0, pk(2,0,'h000,15,1,2,0,0,0));
    add(1,1,2,0,'h800,0,0, pk(2,0,'h000,15,1,2,0,0,0));
    add(1,1,2,0,'h800,0,0, pk(3,0,'h800,15,1,2,0,0,0));
    add(1,1,2,0,'h800,1,0, pk(3,0,'h800,15,1,2,1,0,0));
    add(1,1,2,1,'h800,1,1, pk(3,0,'h800,14,1,2,2,0,0));
    add(1,1,2,0,'h800,1,2, pk(5,0,'h800,14,1,2,3,0,1));
    add(1,1,2,1,'h800,1,11,pk(5,0,'h800,14,1,2,3,0,1));
    add(1,0,2,0,'h800,0,0, pk(0,0,'h800,14,1,2,3,0,0));
    add(1,1,3,0,'h011,0,0, pk(1,1,'h800,10,0,0,0,0,0));
    add(1,1,3,0,'h011,0,0, pk(2,0,'h800,10,0,0,0,0,0));
    add(1,1,3,0,'h011,0,0, pk(2,0,'h800,10,0,0,0,0,0));
    add(1,1,3,0,'h011,0,0, pk(3,0,'h011,10,0,0,0,0,0));
    add(1,1,3,1,'h011,1,0, pk(3,0,'h010, 9,0,1,0,0,0));
    add(1,0,3,0,'h011,1,4, pk(0,0,'h010, 9,0,1,0,0,0));

    foreach (tbl[i]) begin
      rst_sw   = 1'(tbl[i].rst);
      start    = 1'(tbl[i].st);
      mode     = 2'(tbl[i].md);
      tick     = 1'(tbl[i].tk);
      board    = 12'(tbl[i].bd);
      move_vld = 1'(tbl[i].mvv);
      move     = 4'(tbl[i].mv);
      cyc();
      chk($sformatf("vec%0d", i), 64'(dut_v()), 64'(tbl[i].exp));
    end
    move_vld = 1'b0;
    tick = 1'b0;

    // four single-cell boards cleared -> win
    new_game(0, 'h001);
    for (int r = 0; r < ROUNDS; r++) begin
      wait_play();
      move_vld = 1'b1;
      move = 4'd0;
      cyc();
      move_vld = 1'b0;
    end
    chk("win_round", 64'(round), 64'(4));
    chk("win_flag", 64'(win), 64'(1));
    chk("win_state", 64'(state), 64'(4));
    start = 1'b0;
    cyc();
    chk("win_drop_state", 64'(state), 64'(0));
    chk("win_drop_flag", 64'(win), 64'(0));
    chk("win_drop_round", 64'(round), 64'(4));

    // last hit on the same tick that would time out
    new_game(3, 'h001);
    wait_play();
    tick = 1'b1;
    repeat (9) cyc();
    tick = 1'b0;
    chk("tl_one", 64'(time_left), 64'(1));
    tick = 1'b1;
    move_vld = 1'b1;
    move = 4'd0;
    cyc();
    tick = 1'b0;
    move_vld = 1'b0;
    chk("clear_beats_to_state", 64'(state), 64'(1));
    chk("clear_beats_to_round", 64'(round), 64'(1));
    chk("clear_beats_to_lose", 64'(lose), 64'(0));
    chk("clear_beats_to_tl", 64'(time_left), 64'(0));
    wait_play();
    cyc();
    chk("zero_time_lose", 64'(state), 64'(5));

    // plain timeout on mode 3
    new_game(3, 'h001);
    wait_play();
    tick = 1'b1;
    repeat (10) cyc();
    tick = 1'b0;
    chk("timeout_tl", 64'(time_left), 64'(0));
    chk("timeout_lose", 64'(lose), 64'(1));
    chk("timeout_state", 64'(state), 64'(5));

    // two empty boards then a lit one
    new_game(0, 'h000);
    gens = 0;
    prev = 1'b0;
    b2b = 1'b0;
    for (int i = 0; i < 40 && state != 3'd3; i++) begin
      cyc();
      if (gen_en) begin
        gens++;
        if (prev) b2b = 1'b1;
      end
      prev = gen_en;
      if (gens == 3) board = 12'h010;
    end
    chk("regen_play", 64'(state), 64'(3));
    chk("regen_pulses", 64'(gens), 64'(3));
    chk("regen_b2b", 64'(b2b), 64'(0));
    chk("regen_board", 64'(cur_board), 64'(12'h010));

    // randomized play against the model
    for (int i = 0; i < 4000; i++) begin
      rst_sw = (i == 0) ? 1'b0 : 1'(($urandom % 300) != 0);
      if ($urandom % 40 == 0) start = ~start;
      mode = 2'($urandom);
      tick = 1'(($urandom % 4) == 0);
      case ($urandom % 4)
        0: board = '0;
        1: board = 12'd1 << ($urandom % 12);
        2: board = 12'($urandom & $urandom & $urandom);
        default: board = (12'd1 << ($urandom % 12)) |
                         (12'd1 << ($urandom % 12));
      endcase
      move_vld = 1'(($urandom % 3) == 0);
      move = 4'($urandom);
      if (m_cb != 0 && ($urandom % 2) == 1) begin
        int k;
        k = $urandom % 12;
        for (int j = 0; j < 12; j++) begin
          if (m_cb[(k + j) % 12]) begin
            move = 4'((k + j) % 12);
            break;
          end
        end
      end
      model_step();
      cyc();
      chk($sformatf("rand%0d", i), 64'(dut_v()),
          64'(pk(m_phase, m_phase == P_GEN, m_cb, m_time,
                 m_round, m_score, m_miss, m_phase == P_WIN,
                 m_phase == P_LOSE)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
